// File: rtl/arm_hazard_pkg.sv
// arm_hazard_pkg
//   Shared types for the hazard scoreboard: register-index width, the
//   scoreboard entry record and the bubble (empty entry) constant.
package arm_hazard_pkg;

    localparam int unsigned REG_W = 4;

    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic [REG_W-1:0] dest;
        logic             mem_read;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/sb_stage_reg.sv
// sb_stage_reg
//   One scoreboard entry register.
//   clk        : clock
//   rst        : synchronous active-high reset, clears the entry to a bubble
//   hold       : pipeline freeze, entry keeps its value
//   load_entry : entry captured on every unheld clock edge
//   entry      : registered entry
module sb_stage_reg
    import arm_hazard_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      hold,
    input  sb_entry_t load_entry,
    output sb_entry_t entry
);

    sb_entry_t entry_d, entry_q;

    always_comb begin
        entry_d = hold ? entry_q : load_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= SB_BUBBLE;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks register writes in flight through EXE/MEM/WB, publishes each
//   stage's destination and write-enable for forwarding selection, and
//   raises hazard_stall when an ID source depends on a write that cannot
//   be forwarded in time.
//   Inputs : clk, rst (sync, active-high), id_* (ID-stage instruction),
//            forwarding_enabled, freeze (whole pipeline holds),
//            flush (kill the ID instruction)
//   Outputs: hazard_stall (combinational), {exe,mem,wb}_wb_en / _dest
//            (registered), stall_count / bubble_count (saturating)
//   Optional: define HAZARD_STATS_EN to add CNT_W and the two counters.
//   REG_W must equal arm_hazard_pkg::REG_W.
module hazard_scoreboard #(
    parameter int unsigned REG_W = 4
`ifdef HAZARD_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src1_used,
    input  logic             id_src2_used,
    input  logic             id_wb_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_mem_read,
    input  logic             forwarding_enabled,
    input  logic             freeze,
    input  logic             flush,
    output logic             hazard_stall,
    output logic             exe_wb_en,
    output logic             mem_wb_en,
    output logic             wb_wb_en,
    output logic [REG_W-1:0] exe_dest,
    output logic [REG_W-1:0] mem_dest,
    output logic [REG_W-1:0] wb_dest
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] bubble_count
`endif
);

    import arm_hazard_pkg::*;

    sb_entry_t id_entry;
    sb_entry_t exe_d;
    sb_entry_t exe_q, mem_q, wb_q;
    logic      exe_hit, mem_hit, raw_stall, id_accept;
    logic      wb_mem_read_unused;

    function automatic logic src_hit(input logic used, input logic [REG_W-1:0] src,
                                     input sb_entry_t e);
        return used & e.valid & e.wb_en & (src == e.dest);
    endfunction

    always_comb begin
        id_entry  = '{valid: id_valid, wb_en: id_wb_en, dest: id_dest, mem_read: id_mem_read};
        exe_hit   = src_hit(id_src1_used, id_src1, exe_q) | src_hit(id_src2_used, id_src2, exe_q);
        mem_hit   = src_hit(id_src1_used, id_src1, mem_q) | src_hit(id_src2_used, id_src2, mem_q);
        // WB writes the register file before ID reads it, so it never stalls.
        raw_stall = forwarding_enabled ? (exe_hit & exe_q.mem_read) : (exe_hit | mem_hit);
        hazard_stall = id_valid & ~flush & ~freeze & raw_stall;
        id_accept = id_valid & ~hazard_stall & ~flush;
        exe_d     = id_accept ? id_entry : SB_BUBBLE;
    end

    sb_stage_reg u_exe (.clk(clk), .rst(rst), .hold(freeze), .load_entry(exe_d), .entry(exe_q));
    sb_stage_reg u_mem (.clk(clk), .rst(rst), .hold(freeze), .load_entry(exe_q), .entry(mem_q));
    sb_stage_reg u_wb  (.clk(clk), .rst(rst), .hold(freeze), .load_entry(mem_q), .entry(wb_q));

    assign exe_wb_en = exe_q.valid & exe_q.wb_en;
    assign mem_wb_en = mem_q.valid & mem_q.wb_en;
    assign wb_wb_en  = wb_q.valid & wb_q.wb_en;
    assign exe_dest  = exe_q.dest;
    assign mem_dest  = mem_q.dest;
    assign wb_dest   = wb_q.dest;

    // Load status is irrelevant once the write has reached WB.
    assign wb_mem_read_unused = wb_q.mem_read;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (hazard_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (!freeze && !id_accept && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_count  = stall_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed vectors for hazard_scoreboard. Each cycle the driver applies
//   an ID instruction and control inputs and queues the expected outputs;
//   a monitor on the falling edge pops and compares.
//   Expected word: {hazard_stall, exe_wb_en, exe_dest, mem_wb_en, mem_dest,
//                   wb_wb_en, wb_dest}.
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       v;
        logic [3:0] s1;
        logic       u1;
        logic [3:0] s2;
        logic       u2;
        logic       wb;
        logic [3:0] d;
        logic       mr;
    } id_t;

    typedef struct {
        string       nm;
        logic [15:0] e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [3:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
    logic       id_src1_used = 1'b0, id_src2_used = 1'b0;
    logic       id_wb_en = 1'b0, id_mem_read = 1'b0;
    logic       forwarding_enabled = 1'b1, freeze = 1'b0, flush = 1'b0;
    logic       hazard_stall;
    logic       exe_wb_en, mem_wb_en, wb_wb_en;
    logic [3:0] exe_dest, mem_dest, wb_dest;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count, bubble_count;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t expq[$];

    localparam id_t IDLE = '0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_read(id_mem_read),
        .forwarding_enabled(forwarding_enabled), .freeze(freeze), .flush(flush),
        .hazard_stall(hazard_stall),
        .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .wb_wb_en(wb_wb_en),
        .exe_dest(exe_dest), .mem_dest(mem_dest), .wb_dest(wb_dest)
`ifdef HAZARD_STATS_EN
        , .stall_count(stall_count), .bubble_count(bubble_count)
`endif
    );

    function automatic id_t alu(input logic [3:0] d, input logic [3:0] a, input logic [3:0] b);
        return '{v: 1'b1, s1: a, u1: 1'b1, s2: b, u2: 1'b1, wb: 1'b1, d: d, mr: 1'b0};
    endfunction

    function automatic id_t ldr(input logic [3:0] d, input logic [3:0] base);
        return '{v: 1'b1, s1: base, u1: 1'b1, s2: 4'd0, u2: 1'b0, wb: 1'b1, d: d, mr: 1'b1};
    endfunction

    // Sources name the register but are not read (e.g. immediate forms).
    function automatic id_t nouse(input logic [3:0] d, input logic [3:0] a);
        return '{v: 1'b1, s1: a, u1: 1'b0, s2: a, u2: 1'b0, wb: 1'b1, d: d, mr: 1'b0};
    endfunction

    function automatic logic [15:0] ex(input logic st, input logic ew, input logic [3:0] ed,
                                       input logic mw, input logic [3:0] md,
                                       input logic ww, input logic [3:0] wd);
        return {st, ew, ed, mw, md, ww, wd};
    endfunction

    task automatic step(input string nm, input id_t i, input logic fwd, input logic frz,
                        input logic fl, input logic rs, input logic [15:0] e);
        exp_t r;
        @(posedge clk);
        #1;
        rst                = rs;
        id_valid           = i.v;
        id_src1            = i.s1;
        id_src1_used       = i.u1;
        id_src2            = i.s2;
        id_src2_used       = i.u2;
        id_wb_en           = i.wb;
        id_dest            = i.d;
        id_mem_read        = i.mr;
        forwarding_enabled = fwd;
        freeze             = frz;
        flush              = fl;
        r.nm = nm;
        r.e  = e;
        expq.push_back(r);
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    initial begin
        exp_t        r;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                r   = expq.pop_front();
                act = {hazard_stall, exe_wb_en, exe_dest, mem_wb_en, mem_dest, wb_wb_en, wb_dest};
                checks++;
                if (act !== r.e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", r.nm, act, r.e);
                end
            end
        end
    end

    // LDR R3 ; ADD R4,R3,R1 with forwarding: one stall cycle.
    task automatic run_load_use();
        step("lu_ldr",   ldr(3, 1),    1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        step("lu_stall", alu(4, 3, 1), 1, 0, 0, 0, ex(1, 1, 3, 0, 0, 0, 0));
        step("lu_issue", alu(4, 3, 1), 1, 0, 0, 0, ex(0, 0, 0, 1, 3, 0, 0));
        step("lu_d1",    IDLE,         1, 0, 0, 0, ex(0, 1, 4, 0, 0, 1, 3));
        step("lu_d2",    IDLE,         1, 0, 0, 0, ex(0, 0, 0, 1, 4, 0, 0));
        step("lu_d3",    IDLE,         1, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 4));
        step("lu_d4",    IDLE,         1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    endtask

    // ADD R2 ; SUB R5,R2,R2 without forwarding: stalls on EXE then MEM.
    task automatic run_raw_nofwd();
        step("nf_add",    alu(2, 1, 1), 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        step("nf_stall1", alu(5, 2, 2), 0, 0, 0, 0, ex(1, 1, 2, 0, 0, 0, 0));
        step("nf_stall2", alu(5, 2, 2), 0, 0, 0, 0, ex(1, 0, 0, 1, 2, 0, 0));
        step("nf_wb_ok",  alu(5, 2, 2), 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 2));
        step("nf_d1",     IDLE,         0, 0, 0, 0, ex(0, 1, 5, 0, 0, 0, 0));
        step("nf_d2",     IDLE,         0, 0, 0, 0, ex(0, 0, 0, 1, 5, 0, 0));
        step("nf_d3",     IDLE,         0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 5));
        step("nf_d4",     IDLE,         0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);

        // Reset and idle
        step("rst_idle0", IDLE, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
`ifdef HAZARD_STATS_EN
        @(negedge clk);
        chk("rst_stall_count", stall_count, 16'h0000);
`endif
        step("rst_idle1", IDLE, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));

        run_load_use();
        run_raw_nofwd();

        // ALU result with forwarding: no stall
        step("fw_add",  alu(2, 1, 1), 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        step("fw_sub",  alu(5, 2, 2), 1, 0, 0, 0, ex(0, 1, 2, 0, 0, 0, 0));
        step("fw_d1",   IDLE,         1, 0, 0, 0, ex(0, 1, 5, 1, 2, 0, 0));
        step("fw_d2",   IDLE,         1, 0, 0, 0, ex(0, 0, 0, 1, 5, 1, 2));
        step("fw_d3",   IDLE,         1, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 5));
        step("fw_d4",   IDLE,         1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));

        // Matching register index but operand not read: no stall
        step("nu_ldr",  ldr(6, 1),    1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        step("nu_op",   nouse(7, 6),  1, 0, 0, 0, ex(0, 1, 6, 0, 0, 0, 0));
        step("nu_d1",   IDLE,         1, 0, 0, 0, ex(0, 1, 7, 1, 6, 0, 0));
        step("nu_d2",   IDLE,         1, 0, 0, 0, ex(0, 0, 0, 1, 7, 1, 6));
        step("nu_d3",   IDLE,         1, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 7));
        step("nu_d4",   IDLE,         1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));

        // Load-use under a 3-cycle freeze
        step("fz_ldr",   ldr(3, 1),    1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        step("fz_hold1", alu(4, 3, 1), 1, 1, 0, 0, ex(0, 1, 3, 0, 0, 0, 0));
        step("fz_hold2", alu(4, 3, 1), 1, 1, 0, 0, ex(0, 1, 3, 0, 0, 0, 0));
        step("fz_hold3", alu(4, 3, 1), 1, 1, 0, 0, ex(0, 1, 3, 0, 0, 0, 0));
        step("fz_stall", alu(4, 3, 1), 1, 0, 0, 0, ex(1, 1, 3, 0, 0, 0, 0));
        step("fz_issue", alu(4, 3, 1), 1, 0, 0, 0, ex(0, 0, 0, 1, 3, 0, 0));
        step("fz_d1",    IDLE,         1, 0, 0, 0, ex(0, 1, 4, 0, 0, 1, 3));
        step("fz_d2",    IDLE,         1, 0, 0, 0, ex(0, 0, 0, 1, 4, 0, 0));
        step("fz_d3",    IDLE,         1, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 4));
        step("fz_d4",    IDLE,         1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));

        // Load-use coincident with flush: bubble enters EXE
        step("fl_ldr",   ldr(3, 1),    1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        step("fl_kill",  alu(4, 3, 1), 1, 0, 1, 0, ex(0, 1, 3, 0, 0, 0, 0));
        step("fl_bub",   IDLE,         1, 0, 0, 0, ex(0, 0, 0, 1, 3, 0, 0));
        step("fl_d1",    IDLE,         1, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 3));
        step("fl_d2",    IDLE,         1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));

        // Flush held across a freeze takes effect on the first unfrozen cycle
        step("ff_ldr",   ldr(3, 1),    1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        step("ff_frz",   alu(4, 3, 1), 1, 1, 1, 0, ex(0, 1, 3, 0, 0, 0, 0));
        step("ff_kill",  alu(4, 3, 1), 1, 0, 1, 0, ex(0, 1, 3, 0, 0, 0, 0));
        step("ff_d1",    IDLE,         1, 0, 0, 0, ex(0, 0, 0, 1, 3, 0, 0));
        step("ff_d2",    IDLE,         1, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 3));
        step("ff_d3",    IDLE,         1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));

        // Reset mid-hazard discards the in-flight load
        step("mr_ldr",   ldr(3, 1),    1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        step("mr_rst",   alu(4, 3, 1), 1, 0, 0, 1, ex(1, 1, 3, 0, 0, 0, 0));
        step("mr_clear", alu(4, 3, 1), 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        step("mr_d1",    IDLE,         1, 0, 0, 0, ex(0, 1, 4, 0, 0, 0, 0));
        step("mr_d2",    IDLE,         1, 0, 0, 0, ex(0, 0, 0, 1, 4, 0, 0));
        step("mr_d3",    IDLE,         1, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 4));
        step("mr_d4",    IDLE,         1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));

`ifdef HAZARD_STATS_EN
        // Saturation: preload one below all-ones, then three stall cycles
        @(negedge clk);
        force dut.stall_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.stall_cnt_q;
        run_raw_nofwd();
        run_load_use();
        @(negedge clk);
        chk("stall_count_sat", stall_count, 16'hFFFF);
`endif

        for (int k = 0; k < 20 && expq.size() > 0; k++) @(negedge clk);
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
